// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer and transmitter signals shared by uart_tx_arbiter.
// The slave side is the arbiter; the master side is its environment.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_lock;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_lock;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       err_timeout;

  modport slave (
    input  req0_valid, req0_data, req0_lock,
    output req0_ready,
    input  req1_valid, req1_data, req1_lock,
    output req1_ready,
    output tx_start, tx_data,
    input  tx_busy,
    output grant, err_timeout
  );

  modport master (
    output req0_valid, req0_data, req0_lock,
    input  req0_ready,
    output req1_valid, req1_data, req1_lock,
    input  req1_ready,
    input  tx_start, tx_data,
    output tx_busy,
    input  grant, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte producers,
// with per-requester packet lock and a start-acknowledge timeout.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 16,
  parameter int LOCK_HOLD     = 64
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_HOLD + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    data_reg, data_next;
  logic [1:0]    grant_reg, grant_next;
  logic          last_owner_reg, last_owner_next;
  logic          lock_reg, lock_next;
  logic [LW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;

  logic [1:0] valid;
  logic       win;
  logic       accept;
  logic [1:0] ready;
  logic       start;
  logic       err;

  assign valid = {bus.req1_valid, bus.req0_valid};

  always_comb begin
    state_next      = state_reg;
    data_next       = data_reg;
    grant_next      = grant_reg;
    last_owner_next = last_owner_reg;
    lock_next       = lock_reg;
    hold_cnt_next   = hold_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    win             = 1'b0;
    accept          = 1'b0;
    ready           = 2'b00;
    start           = 1'b0;
    err             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (lock_reg) begin
          // Locked: only the packet owner is eligible; an absent owner ages the lock out.
          win = last_owner_reg;
          if (!valid[last_owner_reg]) begin
            if (hold_cnt_reg == LW'(LOCK_HOLD - 1)) begin
              lock_next     = 1'b0;
              hold_cnt_next = '0;
            end else begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
            end
          end
        end else if (valid == 2'b11) begin
          win = ~last_owner_reg;
        end else begin
          win = valid[1];
        end

        accept = valid[win];
        ready  = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

        if (accept) begin
          data_next       = win ? bus.req1_data : bus.req0_data;
          grant_next      = win ? 2'b10 : 2'b01;
          last_owner_next = win;
          lock_next       = win ? bus.req1_lock : bus.req0_lock;
          hold_cnt_next   = '0;
          state_next      = ISSUE;
        end
      end

      ISSUE: begin
        start       = 1'b1;
        to_cnt_next = '0;
        state_next  = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_next = WAIT_DONE;
        end else if (to_cnt_reg == TW'(START_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte and release any packet lock.
          err        = 1'b1;
          lock_next  = 1'b0;
          state_next = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= IDLE;
      data_reg       <= 8'h00;
      grant_reg      <= 2'b00;
      last_owner_reg <= 1'b1;
      lock_reg       <= 1'b0;
      hold_cnt_reg   <= '0;
      to_cnt_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_next;
      grant_reg      <= grant_next;
      last_owner_reg <= last_owner_next;
      lock_reg       <= lock_next;
      hold_cnt_reg   <= hold_cnt_next;
      to_cnt_reg     <= to_cnt_next;
    end
  end

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  assign bus.tx_start    = start;
  assign bus.tx_data     = data_reg;
  assign bus.grant       = grant_reg;
  assign bus.err_timeout = err;
endmodule
